ps2_kbd_arb: RTL and testbench

Two-master Wishbone arbiter that shares the PS/2 keyboard peripheral (event FIFO and status registers) between the CPU (m0) and the on-screen-display/monitor core (m1). Grants are round-robin and held for a whole bus cycle. A watchdog aborts transactions the slave never acknowledges and reports the fault to software. The block sits between the bus interconnect and the keyboard slave.

---
 rtl/ps2_kbd_arb_if.sv | 23 ++
 rtl/ps2_kbd_arb.sv | 171 +++++++++++++++++
 tb/tb_ps2_kbd_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_arb_if.sv
// Pipelined Wishbone bundle used between the keyboard arbiter, its two
// requesters and the PS/2 keyboard slave.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        stall;

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output ack, stall, dat_r
    );

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  ack, stall, dat_r
    );
endinterface

// File: rtl/ps2_kbd_arb.sv
// Round-robin two-master Wishbone arbiter in front of the PS/2 keyboard slave,
// with a no-ack watchdog that aborts the cycle and drains stray slave acks.
module ps2_kbd_arb #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned DRAIN   = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    if_wb.slave        m0,
    if_wb.slave        m1,
    if_wb.master       s,
    input  logic       to_clr_i,
    output logic [1:0] gnt_o,
    output logic       timeout_o,
    output logic       to_src_o,
    output logic [2:0] state_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GNT0  = 3'd1;
    localparam logic [2:0] S_GNT1  = 3'd2;
    localparam logic [2:0] S_ABORT = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned DR_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [DR_W-1:0] DR_LOAD = DR_W'(DRAIN - 1);

    logic [2:0]      state_q, state_d;
    logic            last_gnt_q, last_gnt_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [DR_W-1:0] drain_q, drain_d;
    logic            timeout_q, timeout_d;
    logic            to_src_q, to_src_d;

    logic            req0;
    logic            req1;
    logic            own_cyc;

    // last_gnt_q is loaded on grant entry, so in GNT/ABORT/DRAIN it names
    // the master that owns (or just lost) the bus.
    always_comb begin
        req0       = m0.cyc & m0.stb;
        req1       = m1.cyc & m1.stb;
        own_cyc    = last_gnt_q ? m1.cyc : m0.cyc;
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        wd_d       = '0;
        drain_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (req0 && (!req1 || last_gnt_q)) begin
                    state_d    = S_GNT0;
                    last_gnt_d = 1'b0;
                end else if (req1) begin
                    state_d    = S_GNT1;
                    last_gnt_d = 1'b1;
                end
            end
            S_GNT0, S_GNT1: begin
                if (!own_cyc) begin
                    state_d = S_IDLE;
                end else if (s.ack) begin
                    wd_d = '0;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_ABORT: begin
                state_d = S_DRAIN;
                drain_d = DR_LOAD;
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q - DR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // An abort in the same cycle as a clear request keeps the flag set.
    always_comb begin
        timeout_d = timeout_q;
        to_src_d  = to_src_q;
        if (state_q == S_ABORT) begin
            timeout_d = 1'b1;
            to_src_d  = last_gnt_q;
        end else if (to_clr_i) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            wd_q       <= '0;
            drain_q    <= '0;
            timeout_q  <= 1'b0;
            to_src_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            wd_q       <= wd_d;
            drain_q    <= drain_d;
            timeout_q  <= timeout_d;
            to_src_q   <= to_src_d;
        end
    end

    // Bus steering is purely a function of the registered state, so reset
    // idles both sides immediately.
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.sel    = '0;
        s.adr    = '0;
        s.dat_w  = '0;
        m0.ack   = 1'b0;
        m0.stall = 1'b1;
        m0.dat_r = '0;
        m1.ack   = 1'b0;
        m1.stall = 1'b1;
        m1.dat_r = '0;
        case (state_q)
            S_GNT0: begin
                s.cyc    = m0.cyc;
                s.stb    = m0.stb;
                s.we     = m0.we;
                s.sel    = m0.sel;
                s.adr    = m0.adr;
                s.dat_w  = m0.dat_w;
                m0.ack   = s.ack;
                m0.stall = s.stall;
                m0.dat_r = s.dat_r;
            end
            S_GNT1: begin
                s.cyc    = m1.cyc;
                s.stb    = m1.stb;
                s.we     = m1.we;
                s.sel    = m1.sel;
                s.adr    = m1.adr;
                s.dat_w  = m1.dat_w;
                m1.ack   = s.ack;
                m1.stall = s.stall;
                m1.dat_r = s.dat_r;
            end
            S_ABORT: begin
                m0.ack = ~last_gnt_q;
                m1.ack = last_gnt_q;
            end
            default: begin
            end
        endcase
    end

    assign gnt_o     = {state_q == S_GNT1, state_q == S_GNT0};
    assign timeout_o = timeout_q;
    assign to_src_o  = to_src_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_ps2_kbd_arb.sv
// Bench for ps2_kbd_arb: directed vector table, hand-written watchdog/reset
// sequences and a randomized run against a cycle-level reference model.
module tb_ps2_kbd_arb;
    localparam int TIMEOUT = 16;
    localparam int DRAIN   = 4;
    localparam int OBS_W   = 143;
    localparam int VIEW_W  = 105;

    logic       clk;
    logic       rst_n;
    logic       to_clr;
    logic [1:0] gnt;
    logic       tmo;
    logic       src;
    logic [2:0] state_dbg;

    if_wb m0_if ();
    if_wb m1_if ();
    if_wb s_if ();

    ps2_kbd_arb #(.TIMEOUT(TIMEOUT), .DRAIN(DRAIN)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .to_clr_i (to_clr),
        .gnt_o    (gnt),
        .timeout_o(tmo),
        .to_src_o (src),
        .state_o  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL sim_timeout act=running exp=finished");
        $fatal(1, "bench time limit");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [OBS_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [OBS_W-1:0] act, input logic [OBS_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [VIEW_W-1:0] view();
        return {gnt, s_if.cyc, s_if.adr, m0_if.ack, m0_if.stall, m0_if.dat_r,
                m1_if.ack, m1_if.stall, m1_if.dat_r, tmo, src};
    endfunction

    function automatic logic [VIEW_W-1:0] mk_view(
        input logic [1:0] g, input logic sc, input logic [31:0] sa,
        input logic a0, input logic st0, input logic [31:0] d0,
        input logic a1, input logic st1, input logic [31:0] d1,
        input logic t, input logic sr);
        return {g, sc, sa, a0, st0, d0, a1, st1, d1, t, sr};
    endfunction

    function automatic logic [OBS_W-1:0] act_obs();
        return {gnt, s_if.cyc, s_if.stb, s_if.we, s_if.sel, s_if.adr, s_if.dat_w,
                m0_if.ack, m0_if.stall, m0_if.dat_r, m1_if.ack, m1_if.stall, m1_if.dat_r,
                tmo, src};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic [31:0] adr);
        if (m == 0) begin
            m0_if.cyc = cyc; m0_if.stb = stb; m0_if.adr = adr;
            m0_if.we = 1'b0; m0_if.sel = 4'hf; m0_if.dat_w = 32'h0;
        end else begin
            m1_if.cyc = cyc; m1_if.stb = stb; m1_if.adr = adr;
            m1_if.we = 1'b0; m1_if.sel = 4'hf; m1_if.dat_w = 32'h0;
        end
    endtask

    task automatic idle_inputs();
        drive_m(0, 1'b0, 1'b0, 32'h4);
        drive_m(1, 1'b0, 1'b0, 32'h8);
        s_if.ack   = 1'b0;
        s_if.stall = 1'b0;
        s_if.dat_r = 32'h1;
        to_clr     = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // owner: -1 none, else granted master; last: master most recently granted.
    int md_owner, md_last, md_drain, md_silent;
    bit md_abort;
    logic md_tmo, md_src;

    task automatic model_reset();
        md_owner = -1; md_last = 1; md_drain = 0; md_silent = 0;
        md_abort = 1'b0; md_tmo = 1'b0; md_src = 1'b0;
    endtask

    function automatic logic [OBS_W-1:0] model_obs();
        logic [1:0]  g;
        logic        sc, ss, sw;
        logic [3:0]  ssel;
        logic [31:0] sa, sd, d0, d1;
        logic        a0, st0, a1, st1;
        g = 2'b00; sc = 0; ss = 0; sw = 0; ssel = 0; sa = 0; sd = 0;
        a0 = 0; st0 = 1; d0 = 0; a1 = 0; st1 = 1; d1 = 0;
        if (md_abort) begin
            if (md_last == 0) a0 = 1'b1; else a1 = 1'b1;
        end else if (md_drain > 0) begin
            g = 2'b00;
        end else if (md_owner == 0) begin
            g = 2'b01;
            sc = m0_if.cyc; ss = m0_if.stb; sw = m0_if.we; ssel = m0_if.sel;
            sa = m0_if.adr; sd = m0_if.dat_w;
            a0 = s_if.ack; st0 = s_if.stall; d0 = s_if.dat_r;
        end else if (md_owner == 1) begin
            g = 2'b10;
            sc = m1_if.cyc; ss = m1_if.stb; sw = m1_if.we; ssel = m1_if.sel;
            sa = m1_if.adr; sd = m1_if.dat_w;
            a1 = s_if.ack; st1 = s_if.stall; d1 = s_if.dat_r;
        end
        return {g, sc, ss, sw, ssel, sa, sd, a0, st0, d0, a1, st1, d1, md_tmo, md_src};
    endfunction

    task automatic model_step();
        logic cyc;
        logic r0, r1;
        if (md_abort) begin
            md_abort = 1'b0;
            md_drain = DRAIN;
            md_tmo   = 1'b1;
            md_src   = md_last[0];
        end else begin
            if (to_clr) md_tmo = 1'b0;
            if (md_drain > 0) begin
                md_drain--;
            end else if (md_owner >= 0) begin
                cyc = (md_owner == 1) ? m1_if.cyc : m0_if.cyc;
                if (!cyc) md_owner = -1;
                else if (s_if.ack) md_silent = 0;
                else if (md_silent == TIMEOUT - 1) begin
                    md_abort = 1'b1; md_owner = -1; md_silent = 0;
                end else md_silent++;
            end else begin
                r0 = m0_if.cyc & m0_if.stb;
                r1 = m1_if.cyc & m1_if.stb;
                if (r0 && r1) md_owner = (md_last == 0) ? 1 : 0;
                else if (r0) md_owner = 0;
                else if (r1) md_owner = 1;
                if (md_owner >= 0) begin
                    md_last = md_owner; md_silent = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_state", act_obs(), model_obs());
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic m0c, m0s, m1c, m1s, sack;
        logic [1:0]  gnt;
        logic        scyc;
        logic [31:0] sadr;
        logic        m0ack, m0st, m1ack, m1st;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic m0c, m0s, m1c, m1s, sack, input logic [1:0] g,
                       input logic scyc, input logic [31:0] sadr,
                       input logic m0ack, m0st, m1ack, m1st);
        vec_t v;
        v.m0c = m0c; v.m0s = m0s; v.m1c = m1c; v.m1s = m1s; v.sack = sack;
        v.gnt = g; v.scyc = scyc; v.sadr = sadr;
        v.m0ack = m0ack; v.m0st = m0st; v.m1ack = m1ack; v.m1st = m1st;
        vt.push_back(v);
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();

        // simultaneous requests, four rounds: winners alternate 0,1,0,1
        for (int r = 0; r < 4; r++) begin
            logic w;
            w = r[0];
            add(1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 1);
            add(1, 1, 1, 1, 1, w ? 2'b10 : 2'b01, 1, w ? 32'h8 : 32'h4, !w, w, w, !w);
            add(0, 0, 0, 0, 0, w ? 2'b10 : 2'b01, 0, w ? 32'h8 : 32'h4, 0, w, 0, !w);
        end
        // m0 reads 0x4 alone
        add(1, 1, 0, 0, 0, 2'b00, 0, 0,     0, 1, 0, 1);
        add(1, 1, 0, 0, 1, 2'b01, 1, 32'h4, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 2'b01, 0, 32'h4, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 2'b00, 0, 0,     0, 1, 0, 1);
        // m1 holds cyc over three reads while m0 waits
        add(0, 0, 1, 1, 0, 2'b00, 0, 0,     0, 1, 0, 1);
        add(1, 1, 1, 1, 1, 2'b10, 1, 32'h8, 0, 1, 1, 0);
        add(1, 1, 1, 0, 0, 2'b10, 1, 32'h8, 0, 1, 0, 0);
        add(1, 1, 1, 1, 1, 2'b10, 1, 32'h8, 0, 1, 1, 0);
        add(1, 1, 1, 1, 1, 2'b10, 1, 32'h8, 0, 1, 1, 0);
        add(1, 1, 0, 0, 0, 2'b10, 0, 32'h8, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 2'b00, 0, 0,     0, 1, 0, 1);
        add(1, 1, 0, 0, 1, 2'b01, 1, 32'h4, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 2'b01, 0, 32'h4, 0, 0, 0, 1);
        // stb without cyc never requests
        add(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 1, 0, 1);
        add(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 1, 0, 1);
        add(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 1, 0, 1);

        do_reset();
        foreach (vt[i]) begin
            step();
            drive_m(0, vt[i].m0c, vt[i].m0s, 32'h4);
            drive_m(1, vt[i].m1c, vt[i].m1s, 32'h8);
            s_if.ack = vt[i].sack;
            @(negedge clk);
            check($sformatf("vec%0d", i), view(),
                  mk_view(vt[i].gnt, vt[i].scyc, vt[i].sadr,
                          vt[i].m0ack, vt[i].m0st, (vt[i].gnt == 2'b01) ? 32'h1 : 32'h0,
                          vt[i].m1ack, vt[i].m1st, (vt[i].gnt == 2'b10) ? 32'h1 : 32'h0,
                          1'b0, 1'b0));
        end

        // watchdog abort on m0, stray ack in drain, tie after drain, clear
        do_reset();
        step();
        drive_m(0, 1, 1, 32'h4);
        @(negedge clk);
        check("to_idle", view(), mk_view(2'b00, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        for (int k = 1; k <= TIMEOUT; k++) begin
            step();
            @(negedge clk);
            check($sformatf("to_wait%0d", k), view(), mk_view(2'b01, 1, 32'h4, 0, 0, 32'h1, 0, 1, 0, 0, 0));
        end
        step();
        drive_m(0, 0, 0, 32'h4);
        @(negedge clk);
        check("to_abort", view(), mk_view(2'b00, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k < DRAIN; k++) begin
            step();
            s_if.ack = (k == 0);
            drive_m(1, 1, 1, 32'h8);
            if (k >= 1) drive_m(0, 1, 1, 32'h4);
            @(negedge clk);
            check($sformatf("to_drain%0d", k), view(), mk_view(2'b00, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0));
        end
        step();
        s_if.ack = 1'b0;
        @(negedge clk);
        check("to_post_idle", view(), mk_view(2'b00, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0));
        step();
        @(negedge clk);
        check("to_tie_m1", view(), mk_view(2'b10, 1, 32'h8, 0, 1, 0, 0, 0, 32'h1, 1, 0));
        step();
        drive_m(0, 0, 0, 32'h4);
        drive_m(1, 0, 0, 32'h8);
        to_clr = 1'b1;
        @(negedge clk);
        check("to_clr_pulse", view(), mk_view(2'b10, 0, 32'h8, 0, 1, 0, 0, 0, 32'h1, 1, 0));
        step();
        to_clr = 1'b0;
        @(negedge clk);
        check("to_cleared", view(), mk_view(2'b00, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));

        // ack exactly when the watchdog reaches its last count
        do_reset();
        step();
        drive_m(0, 1, 1, 32'h4);
        for (int k = 1; k < TIMEOUT; k++) step();
        step();
        s_if.ack = 1'b1;
        @(negedge clk);
        check("bnd_ack", view(), mk_view(2'b01, 1, 32'h4, 1, 0, 32'h1, 0, 1, 0, 0, 0));
        step();
        s_if.ack = 1'b0;
        drive_m(0, 0, 0, 32'h4);
        @(negedge clk);
        check("bnd_no_abort", view(), mk_view(2'b01, 0, 32'h4, 0, 0, 32'h1, 0, 1, 0, 0, 0));
        step();
        @(negedge clk);
        check("bnd_idle", view(), mk_view(2'b00, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));

        // asynchronous reset while m1 owns the bus
        do_reset();
        step();
        drive_m(1, 1, 1, 32'h8);
        step();
        s_if.ack = 1'b1;
        @(negedge clk);
        check("rst_pre", view(), mk_view(2'b10, 1, 32'h8, 0, 1, 0, 1, 0, 32'h1, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", view(), mk_view(2'b00, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        @(posedge clk);
        idle_inputs();
        #2 rst_n = 1'b1;
        step();
        drive_m(0, 1, 1, 32'h4);
        drive_m(1, 1, 1, 32'h8);
        step();
        @(negedge clk);
        check("rst_then_m0", view(), mk_view(2'b01, 1, 32'h4, 0, 0, 32'h1, 0, 1, 0, 0, 0));

        // randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic quiet;
            step();
            quiet = ((c / 100) % 3) == 2;
            m0_if.cyc   = m0_if.cyc ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            m0_if.stb   = $urandom_range(0, 3) != 0;
            m0_if.we    = 1'($urandom_range(0, 1));
            m0_if.sel   = 4'($urandom);
            m0_if.adr   = $urandom;
            m0_if.dat_w = $urandom;
            m1_if.cyc   = m1_if.cyc ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            m1_if.stb   = $urandom_range(0, 3) != 0;
            m1_if.we    = 1'($urandom_range(0, 1));
            m1_if.sel   = 4'($urandom);
            m1_if.adr   = $urandom;
            m1_if.dat_w = $urandom;
            s_if.ack    = !quiet && ($urandom_range(0, 2) == 0);
            s_if.stall  = 1'($urandom_range(0, 1));
            s_if.dat_r  = $urandom;
            to_clr      = $urandom_range(0, 15) == 0;
            @(negedge clk);
            exp_q.push_back(model_obs());
            check("rand", act_obs(), exp_q.pop_front());
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
